// File: rtl/alu_pkg.sv
// ============================================================================
//  Module : alu_pkg
//  Opcode encodings and flag-vector bit positions shared by the ALU pipeline.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   localparam int FLG_S  = 0;
   localparam int FLG_CR = 1;
   localparam int FLG_ZE = 2;
   localparam int FLG_P  = 3;
   localparam int FLG_O  = 4;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
//  Module : alu_core
//  Combinational 8-operation ALU producing the result and a packed flag vector.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] Z,
   output logic [4:0]       flags
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_z;
   logic             w_cr;
   logic             w_o;

   // One extra bit on the unsigned sum/difference captures carry-out or borrow.
   assign w_sum  = {1'b0, X} + {1'b0, Y};
   assign w_diff = {1'b0, X} - {1'b0, Y};

   always_comb begin
      w_z  = '0;
      w_cr = 1'b0;
      w_o  = 1'b0;
      case (op)
         OP_ADD: begin
            w_z  = w_sum[WIDTH-1:0];
            w_cr = w_sum[WIDTH];
            w_o  = (X[WIDTH-1] == Y[WIDTH-1]) && (w_sum[WIDTH-1] != X[WIDTH-1]);
         end
         OP_SUB: begin
            w_z  = w_diff[WIDTH-1:0];
            w_cr = w_diff[WIDTH];
            w_o  = (X[WIDTH-1] != Y[WIDTH-1]) && (w_diff[WIDTH-1] != X[WIDTH-1]);
         end
         OP_AND: w_z = X & Y;
         OP_OR:  w_z = X | Y;
         OP_XOR: w_z = X ^ Y;
         OP_NOT: w_z = ~X;
         OP_SHL: begin
            w_z  = {X[WIDTH-2:0], 1'b0};
            w_cr = X[WIDTH-1];
         end
         default: begin
            w_z  = {1'b0, X[WIDTH-1:1]};
            w_cr = X[0];
         end
      endcase
   end

   always_comb begin
      flags         = '0;
      flags[FLG_S]  = w_z[WIDTH-1];
      flags[FLG_CR] = w_cr;
      flags[FLG_ZE] = (w_z == '0);
      flags[FLG_P]  = ~^w_z;
      flags[FLG_O]  = w_o;
   end

   assign Z = w_z;

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
//  Module : alu_pipe
//  Two-stage valid/ready ALU pipeline with registered result, flags and count.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Z,
   output logic             S,
   output logic             Cr,
   output logic             Ze,
   output logic             P,
   output logic             O,
   output logic [CNT_W-1:0] op_count
);

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [2:0]       r_op;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_z;
   logic [4:0]       r_flags;
   logic [CNT_W-1:0] r_count;

   logic             w_adv1;
   logic             w_adv2;
   logic [WIDTH-1:0] w_z;
   logic [4:0]       w_flags;

   // Ready ripples back combinationally so a full pipe still streams one op per cycle.
   assign w_adv2   = !r_s2_valid || out_ready;
   assign w_adv1   = !r_s1_valid || w_adv2;
   assign in_ready = w_adv1;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .X     (r_x),
      .Y     (r_y),
      .op    (r_op),
      .Z     (w_z),
      .flags (w_flags)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_x        <= '0;
         r_y        <= '0;
         r_op       <= '0;
         r_s2_valid <= 1'b0;
         r_z        <= '0;
         r_flags    <= '0;
         r_count    <= '0;
      end else begin
         if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
               r_x  <= X;
               r_y  <= Y;
               r_op <= op;
            end
         end
         if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_z     <= w_z;
               r_flags <= w_flags;
            end
         end
         if (r_s2_valid && out_ready)
            r_count <= r_count + CNT_W'(1);
      end
   end

   assign out_valid = r_s2_valid;
   assign Z         = r_z;
   assign S         = r_flags[FLG_S];
   assign Cr        = r_flags[FLG_CR];
   assign Ze        = r_flags[FLG_ZE];
   assign P         = r_flags[FLG_P];
   assign O         = r_flags[FLG_O];
   assign op_count  = r_count;

endmodule

`default_nettype wire
